word_narrow_16_8: RTL
=====================

# word_narrow_16_8

Serializes 16-bit datapath words onto an 8-bit byte stream for the byte-wide memory/IO side of the single-cycle RISC. It performs the inverse of 8→16 sign extension. A word whose high byte equals the sign replication of its low byte is sent as one byte flagged `out_fits`. Any other word is sent as two bytes, high byte first. Input and output use valid/ready handshakes, and a saturating counter records how many words were compressed.

## Interface
- `FORCE_WIDE`, default 0: when 1, compression is disabled and every word is sent as two bytes.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in 16: word to narrow.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the byte this cycle.
- `out_data` out 8: byte being sent.
- `out_last` out 1: this byte is the final byte of its word.
- `out_fits` out 1: word was compressed to this single byte.
- `short_cnt` out 16: saturating count of compressed words.

## Operation
- **Fit rule:** `fits = (in_data[15:8] == {8{in_data[7]}}) && !FORCE_WIDE`.
- **States:** IDLE, ONE, HI, LO. A 16-bit `word` register latches `in_data` on accept.
- **Accept:** occurs when `in_valid && in_ready`.
  - Next state is ONE if `fits`, otherwise HI.
- **Byte driven in each state:**
  - ONE: `out_data = word[7:0]`, `out_last = 1`, `out_fits = 1`.
  - HI: `out_data = word[15:8]`, `out_last = 0`, `out_fits = 0`.
  - LO: `out_data = word[7:0]`, `out_last = 1`, `out_fits = 0`.
- **Valid:** `out_valid = (state != IDLE)`.
- **Transitions on output handshake** (`out_valid && out_ready`):
  - HI→LO.
  - ONE or LO → IDLE, unless a new word is accepted the same cycle, in which case the next state is ONE or HI per that word's fit rule.
- **`in_ready`:** `!rst && (state == IDLE || (out_ready && out_last))`. This allows back-to-back words with no bubble.
- **No handshake:** state and `word` hold; `out_data`, `out_last` and `out_fits` stay stable while `out_valid && !out_ready`.
- **Counter:** `short_cnt` increments by 1 on each handshake in state ONE. It saturates at 0xFFFF and never wraps.
- **Output sourcing:**
  - `out_*` outputs are decoded from registers only.
  - `in_ready` is the only output with a combinational path from an input (`out_ready`).

## Timing
- **Reset values:**
  - state = IDLE, `word` = 0, `short_cnt` = 0.
  - `out_valid` = 0, `out_data` = 0x00, `out_last` = 0, `out_fits` = 0.
  - `in_ready` = 0 while `rst` is high.
- **Latency:** the first byte of an accepted word appears on the cycle after accept.
- **Throughput:** 1 byte/cycle sustained with `out_ready` held high; 2 cycles for a wide word, 1 for a compressed word.
- **Reset mid-word:** asserting `rst` in any state aborts the word.
  - The remaining bytes are dropped.
  - `short_cnt` clears.
  - The first post-reset accept is possible the cycle after `rst` deasserts.
- **`in_valid` with `in_ready` low:** no effect. The upstream source holds the word.
- **Simultaneous final handshake + accept:** the new byte appears the next cycle, with no idle cycle.

## Structure
- **Shared package:** `narrow_defs` holds the state encodings (IDLE=2'd0, ONE=2'd1, HI=2'd2, LO=2'd3) and `BYTE_W = 8`. It is reused by the future byte→word assembler.
- **Sub-module:** `fits_signed_8`, a combinational 16-bit input / 1-bit fit output. It is the exact complement of the sign-extension rule and is unit-tested alone.
- **Top level:** contains the FSM, the `word` register and the counter.

## Test plan
1. **Single-byte words:**
   - In: 0x007F, then 0xFF80, with `out_ready` = 1.
   - Out: byte 0x7F then byte 0x80.
   - Each byte has `last` = 1 and `fits` = 1; `short_cnt` = 2.
2. **Wide word with stall:**
   - In: 0x1234, with `out_ready` held low for 3 cycles.
   - Out: 0x12 holds stable with `last` = 0 during the stall.
   - Then 0x34 with `last` = 1, `fits` = 0.
   - `in_ready` stays low until the 0x34 handshake.
3. **Boundary and back-to-back:**
   - In: 0x0080, 0xFFFF, 0x0100 back-to-back.
   - Out: 00, 80, FF(fits), 01, 00 on consecutive cycles with no bubble.
4. **Reset mid-word:**
   - Assert `rst` while in LO for 0xABCD.
   - Next cycle: `out_valid` = 0 and `short_cnt` = 0.
   - A following 0x0001 produces a single byte 0x01.
5. **`FORCE_WIDE` = 1:**
   - In: 0x0005.
   - Out: 0x00 then 0x05, `fits` = 0; `short_cnt` stays 0.
6. **Counter saturation:**
   - Preload by driving 65,537 compressed words.
   - `short_cnt` holds at 0xFFFF.

Source files
------------

// File: rtl/word_narrow_16_8_pkg.sv
// Shared definitions for the word/byte narrowing and assembling blocks.
package narrow_defs;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } state_t;

endpackage

// File: rtl/fits_signed_8.sv
// Flags a 16-bit word whose high byte is the sign replication of its low byte,
// i.e. a word that 8->16 sign extension would reproduce exactly.
module fits_signed_8
  import narrow_defs::*;
(
  input  logic [WORD_W-1:0] data,
  output logic              fits
);

  assign fits = (data[WORD_W-1:BYTE_W] == {BYTE_W{data[BYTE_W-1]}});

endmodule

// File: rtl/word_narrow_16_8.sv
// Serializes 16-bit words onto a byte stream, sending sign-extendable words as
// a single flagged byte and all others high byte first.
//
// state | meaning
// IDLE  | no word held, out_valid low
// ONE   | sending the single compressed byte
// HI    | sending the high byte of a wide word
// LO    | sending the low byte of a wide word
module word_narrow_16_8
  import narrow_defs::*;
#(
  parameter bit FORCE_WIDE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              out_fits,
  output logic [15:0]       short_cnt
);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic              fits_raw;
  logic              fits;
  logic              accept;
  logic              out_hs;

  fits_signed_8 u_fits (
    .data (in_data),
    .fits (fits_raw)
  );

  assign fits = fits_raw && !FORCE_WIDE;

  // All out_* signals decode from state and word only.
  assign out_valid = (state != IDLE);
  assign out_last  = (state == ONE) || (state == LO);
  assign out_fits  = (state == ONE);

  always_comb begin
    out_data = '0;
    case (state)
      HI:      out_data = word[WORD_W-1:BYTE_W];
      ONE, LO: out_data = word[BYTE_W-1:0];
      default: out_data = '0;
    endcase
  end

  // Accepting during the final byte handshake keeps the stream bubble-free.
  assign in_ready = !rst && ((state == IDLE) || (out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      short_cnt <= '0;
    end else begin
      if (out_hs && (state == ONE) && (short_cnt != 16'hFFFF))
        short_cnt <= short_cnt + 16'd1;

      if (accept) begin
        word  <= in_data;
        state <= fits ? ONE : HI;
      end else if (out_hs) begin
        case (state)
          HI:      state <= LO;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
